// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding and the baud divider helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;
  localparam int unsigned OVERSAMPLE  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, phase realigned by clr.
module uart_baud_gen #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : gen_div_check
    $error("uart_baud_gen: DIV must be at least 2");
  end

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    tick  = (cnt_q == CntW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: majority vote, false-start rejection, frame/parity errors.
// Define UART_RX_BREAK_DET_EN to add the break_det output and the BREAK state.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 break_det,
`endif
  output logic                 busy
);

  localparam int unsigned Div = calc_div(CLK_FREQ, BAUD);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2)
  begin : gen_param_check
    $error("uart_rx_os: illegal DATA_BITS, PARITY or STOP_BITS");
  end

  // Line idles high, so the synchroniser resets to 1 to avoid a spurious start edge.
  logic sync1_q, sync2_q, sync3_q;
  logic rx_s, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rx_s = sync2_q;
  assign fall = sync3_q & ~sync2_q;

  logic tick, clr;

  uart_baud_gen #(
    .DIV(Div)
  ) u_baud_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  uart_state_e          state_d, state_q;
  logic [3:0]           s_cnt_d, s_cnt_q;
  logic [3:0]           bit_idx_d, bit_idx_q;
  logic                 stop_idx_d, stop_idx_q;
  logic                 v7_d, v7_q, v8_d, v8_q, bit_d, bit_q;
  logic [DATA_BITS-1:0] shift_d, shift_q, rx_data_d, rx_data_q;
  logic                 perr_acc_d, perr_acc_q, ferr_acc_d, ferr_acc_q;
  logic                 par_bit_d, par_bit_q;
  logic                 rx_done_d, rx_done_q;
  logic                 frame_err_d, frame_err_q, parity_err_d, parity_err_q;
  logic                 maj, stop_bad, last_stop;
`ifdef UART_RX_BREAK_DET_EN
  logic                 break_det_d, break_det_q;
`endif

  always_comb begin
    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    v7_d         = v7_q;
    v8_d         = v8_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    perr_acc_d   = perr_acc_q;
    ferr_acc_d   = ferr_acc_q;
    par_bit_d    = par_bit_q;
    rx_data_d    = rx_data_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    rx_done_d    = 1'b0;
    clr          = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    break_det_d  = break_det_q;
`endif
    // The third vote sample is the live synchronised line at count 9.
    maj       = (v7_q & v8_q) | (v7_q & rx_s) | (v8_q & rx_s);
    stop_bad  = ferr_acc_q | ~maj;
    last_stop = (STOP_BITS == 1) || stop_idx_q;

    if (tick) begin
      s_cnt_d = s_cnt_q + 4'd1;
      if (s_cnt_q == 4'd7) v7_d = rx_s;
      if (s_cnt_q == 4'd8) v8_d = rx_s;
      if (s_cnt_q == 4'd9) bit_d = maj;
    end

    unique case (state_q)
      StIdle: begin
        s_cnt_d = '0;
        if (fall) begin
          clr     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick && s_cnt_q == 4'd9 && maj) begin
          state_d = StIdle;
        end else if (tick && s_cnt_q == 4'd15) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (tick && s_cnt_q == 4'd15) begin
          shift_d = {bit_q, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == 4'(DATA_BITS - 1)) begin
            state_d    = (PARITY != PARITY_NONE) ? StParity : StStop;
            stop_idx_d = 1'b0;
            ferr_acc_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (tick && s_cnt_q == 4'd15) begin
          par_bit_d  = bit_q;
          perr_acc_d = bit_q != ((^shift_q) ^ (PARITY == PARITY_ODD));
          state_d    = StStop;
        end
      end
      StStop: begin
        // Finish at count 9 of the last stop bit so the next start edge is never missed.
        if (tick && s_cnt_q == 4'd9) begin
          if (last_stop) begin
            rx_data_d    = shift_q;
            frame_err_d  = stop_bad;
            parity_err_d = perr_acc_q;
            rx_done_d    = 1'b1;
            state_d      = StIdle;
`ifdef UART_RX_BREAK_DET_EN
            if (stop_bad && shift_q == '0 && !par_bit_q) begin
              break_det_d = 1'b1;
              state_d     = StBreak;
              s_cnt_d     = '0;
            end
`endif
          end else begin
            ferr_acc_d = ~maj;
          end
        end else if (tick && s_cnt_q == 4'd15) begin
          stop_idx_d = 1'b1;
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      StBreak: begin
        // s_cnt counts consecutive high samples here.
        if (tick) begin
          if (!rx_s) begin
            s_cnt_d = '0;
          end else if (s_cnt_q == 4'd15) begin
            s_cnt_d     = '0;
            break_det_d = 1'b0;
            state_d     = StIdle;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      s_cnt_q      <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      v7_q         <= 1'b1;
      v8_q         <= 1'b1;
      bit_q        <= 1'b1;
      shift_q      <= '0;
      perr_acc_q   <= 1'b0;
      ferr_acc_q   <= 1'b0;
      par_bit_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      s_cnt_q      <= s_cnt_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      v7_q         <= v7_d;
      v8_q         <= v8_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      perr_acc_q   <= perr_acc_d;
      ferr_acc_q   <= ferr_acc_d;
      par_bit_q    <= par_bit_d;
      rx_data_q    <= rx_data_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
`ifdef UART_RX_BREAK_DET_EN
      break_det_q  <= break_det_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_done    = rx_done_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q != StIdle);
`ifdef UART_RX_BREAK_DET_EN
  assign break_det  = break_det_q;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Randomised self-checking bench for uart_rx_os: three configurations (8N1, 7E1, 8N2)
// checked against a frame-level reference model.
module tb_uart_rx_os;

  localparam int Bit  = 432;  // clk per bit at 50 MHz / 115200 baud, DIV = 27
  localparam int Tick = 27;

  typedef struct {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line [3];
  logic [7:0] data0, data2;
  logic [6:0] data1;
  logic       done0, done1, done2, ferr0, ferr1, ferr2, perr0, perr1, perr2;
  logic       busy0, busy1, busy2;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk0, brk1, brk2;
`endif

  int         n_checks = 0;
  int         n_pass = 0;
  int         done_cnt [3] = '{0, 0, 0};
  logic [8:0] cap_data [3];
  logic       cap_ferr [3];
  logic       cap_perr [3];
  logic       cap_brk  [3];

  always #10 clk = ~clk;

  uart_rx_os u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx_line[0]),
    .rx_data   (data0),
    .rx_done   (done0),
    .frame_err (ferr0),
    .parity_err(perr0),
`ifdef UART_RX_BREAK_DET_EN
    .break_det (brk0),
`endif
    .busy      (busy0)
  );

  uart_rx_os #(
    .DATA_BITS(7),
    .PARITY   (2)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx_line[1]),
    .rx_data   (data1),
    .rx_done   (done1),
    .frame_err (ferr1),
    .parity_err(perr1),
`ifdef UART_RX_BREAK_DET_EN
    .break_det (brk1),
`endif
    .busy      (busy1)
  );

  uart_rx_os #(
    .STOP_BITS(2)
  ) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx_line[2]),
    .rx_data   (data2),
    .rx_done   (done2),
    .frame_err (ferr2),
    .parity_err(perr2),
`ifdef UART_RX_BREAK_DET_EN
    .break_det (brk2),
`endif
    .busy      (busy2)
  );

  always @(negedge clk) begin
    if (done0) begin
      done_cnt[0]++;
      cap_data[0] = {1'b0, data0};
      cap_ferr[0] = ferr0;
      cap_perr[0] = perr0;
`ifdef UART_RX_BREAK_DET_EN
      cap_brk[0] = brk0;
`endif
    end
    if (done1) begin
      done_cnt[1]++;
      cap_data[1] = {2'b0, data1};
      cap_ferr[1] = ferr1;
      cap_perr[1] = perr1;
    end
    if (done2) begin
      done_cnt[2]++;
      cap_data[2] = {1'b0, data2};
      cap_ferr[2] = ferr2;
      cap_perr[2] = perr2;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [8:0] cur_data(input int d);
    case (d)
      0:       return {1'b0, data0};
      1:       return {2'b0, data1};
      default: return {1'b0, data2};
    endcase
  endfunction

  function automatic logic cur_busy(input int d);
    case (d)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  // Frame-level model: what a receiver of this configuration must report for a frame.
  function automatic exp_t model(input int nbits, input int pmode, input logic [8:0] data,
                                 input logic par_bit, input logic [1:0] stops, input int nstop);
    exp_t e;
    int   ones;
    e.data = 9'(int'(data) % (1 << nbits));
    ones   = $countones(e.data);
    if (pmode == 1)      e.perr = (par_bit != ((ones % 2) == 0));
    else if (pmode == 2) e.perr = (par_bit != ((ones % 2) == 1));
    else                 e.perr = 1'b0;
    e.ferr = 1'b0;
    for (int i = 0; i < nstop; i++) if (!stops[i]) e.ferr = 1'b1;
    e.brk = e.ferr && (e.data == 0) && (pmode == 0 || !par_bit);
    return e;
  endfunction

  task automatic drive_bit(input int d, input logic v, input int len);
    rx_line[d] = v;
    repeat (len) @(posedge clk);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_frame(input int d, input logic [8:0] data, input logic par_bit,
                          input logic [1:0] stops, input string tag);
    int   nb, pm, ns, c0;
    exp_t e;
    nb = (d == 1) ? 7 : 8;
    pm = (d == 1) ? 2 : 0;
    ns = (d == 2) ? 2 : 1;
    e  = model(nb, pm, data, par_bit, stops, ns);
    c0 = done_cnt[d];
    drive_bit(d, 1'b0, Bit);
    for (int i = 0; i < nb; i++) drive_bit(d, data[i], Bit);
    if (pm != 0) drive_bit(d, par_bit, Bit);
    for (int i = 0; i < ns; i++) drive_bit(d, stops[i], Bit);
    drive_bit(d, 1'b1, Bit / 2 + int'($urandom_range(0, 100)));
    settle();
    check_eq({tag, ".done_pulses"}, 32'(done_cnt[d] - c0), 32'd1);
    check_eq({tag, ".rx_data"}, 32'(cap_data[d]), 32'(e.data));
    check_eq({tag, ".frame_err"}, 32'(cap_ferr[d]), 32'(e.ferr));
    check_eq({tag, ".parity_err"}, 32'(cap_perr[d]), 32'(e.perr));
    check_eq({tag, ".rx_data_held"}, 32'(cur_data(d)), 32'(e.data));
    check_eq({tag, ".busy_after"}, 32'(cur_busy(d)), 32'd0);
  endtask

  initial begin
    logic [8:0] dat;
    logic [1:0] stp;
    int         c0;
    for (int i = 0; i < 3; i++) rx_line[i] = 1'b1;
    repeat (5) @(posedge clk);
    settle();
    check_eq("reset.rx_done", 32'(done0), 32'd0);
    check_eq("reset.rx_data", 32'(data0), 32'd0);
    check_eq("reset.frame_err", 32'(ferr0), 32'd0);
    check_eq("reset.parity_err", 32'(perr1), 32'd0);
    check_eq("reset.busy", 32'(busy2), 32'd0);
`ifdef UART_RX_BREAK_DET_EN
    check_eq("reset.break_det", 32'(brk0), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // 8N1
    do_frame(0, 9'h55, 1'b0, 2'b11, "d0_55");
    do_frame(0, 9'h0F, 1'b0, 2'b10, "d0_0f_stop_low");
    do_frame(0, 9'hA5, 1'b0, 2'b11, "d0_a5");
    for (int k = 0; k < 2; k++) begin
      dat = 9'($urandom_range(1, 255));
      stp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      do_frame(0, dat, 1'b0, stp, $sformatf("d0_rand%0d", k));
    end

    // Short low glitch on an idle line must be rejected as a false start
    c0 = done_cnt[0];
    drive_bit(0, 1'b0, 5);
    drive_bit(0, 1'b1, 6);
    settle();
    check_eq("glitch.busy_started", 32'(busy0), 32'd1);
    repeat (11 * Tick - 12) @(posedge clk);
    settle();
    check_eq("glitch.busy_cleared", 32'(busy0), 32'd0);
    check_eq("glitch.no_done", 32'(done_cnt[0] - c0), 32'd0);

    // 7E1
    do_frame(1, 9'h3A, 1'b0, 2'b11, "d1_3a_par_ok");
    do_frame(1, 9'h3A, 1'b1, 2'b11, "d1_3a_par_bad");
    do_frame(1, 9'($urandom_range(1, 127)), 1'($urandom_range(0, 1)), 2'b11, "d1_rand");

    // 8N2
    do_frame(2, 9'hC3, 1'b0, 2'b01, "d2_c3_stop2_low");
    do_frame(2, 9'($urandom_range(1, 255)), 1'b0, 2'($urandom_range(0, 3)), "d2_rand");

    // Reset in the middle of the data bits of 0x81
    c0 = done_cnt[0];
    drive_bit(0, 1'b0, Bit);
    drive_bit(0, 1'b1, Bit);
    drive_bit(0, 1'b0, Bit);
    drive_bit(0, 1'b0, Bit / 2);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    settle();
    check_eq("midrst.rx_data", 32'(data0), 32'd0);
    check_eq("midrst.frame_err", 32'(ferr0), 32'd0);
    check_eq("midrst.busy", 32'(busy0), 32'd0);
    rst_n = 1'b1;
    drive_bit(0, 1'b1, 2 * Bit);
    settle();
    check_eq("midrst.no_done", 32'(done_cnt[0] - c0), 32'd0);
    do_frame(0, 9'h81, 1'b0, 2'b11, "d0_81_after_rst");

`ifdef UART_RX_BREAK_DET_EN
    c0 = done_cnt[0];
    drive_bit(0, 1'b0, 12 * Bit);
    settle();
    check_eq("break.done_pulses", 32'(done_cnt[0] - c0), 32'd1);
    check_eq("break.rx_data", 32'(cap_data[0]), 32'd0);
    check_eq("break.frame_err", 32'(cap_ferr[0]), 32'd1);
    check_eq("break.break_det_at_done", 32'(cap_brk[0]), 32'd1);
    check_eq("break.break_det_held", 32'(brk0), 32'd1);
    drive_bit(0, 1'b1, 10 * Tick);
    settle();
    check_eq("break.still_set", 32'(brk0), 32'd1);
    drive_bit(0, 1'b1, 8 * Tick + 10);
    settle();
    check_eq("break.cleared", 32'(brk0), 32'd0);
    check_eq("break.busy_cleared", 32'(busy0), 32'd0);
`else
    do_frame(0, 9'h00, 1'b0, 2'b10, "d0_break_frame");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised 16x-oversampling UART receiver; successor to the fixed 8N1 receive path in uart_top.
- Configurable data width, parity mode and stop-bit count.
- Majority-vote sampling, false-start rejection, frame/parity error reporting.
- Drives rx_data/rx_done toward uart_top's host side; the serial pin enters via an internal synchroniser.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits checked: 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  received payload, LSB received first.
- rx_done  output  1  one-cycle pulse when a frame completes (good or errored).
- frame_err  output  1  stop bit sampled low; valid with rx_done.
- parity_err  output  1  parity mismatch; valid with rx_done; always 0 when PARITY=0.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0; FSM to IDLE; counters 0; synchroniser flops set to 1 (idle line).
- Synchroniser: 2-FF on rx, then a third flop for edge detection; 2-cycle input latency.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*16), integer truncation; elaboration error if DIV < 2.
  - Counter runs 0..DIV-1 and emits a 1-cycle tick at DIV-1.
  - Free-running except it is cleared on entry to START, which aligns the sample phase.
- Sample counter: 4 bits, 0..15, advances on tick. Bit value = majority of samples at counts 7, 8, 9.
- IDLE:
  - Leave on a synchronised falling edge (1->0) -> START.
  - Sample counter cleared.
- START:
  - At count 9, majority = 1 -> false start, back to IDLE with no outputs.
  - At count 15, majority = 0 -> DATA, bit index 0.
- DATA:
  - Shift the voted bit into shift register position bit_idx at count 15.
  - After DATA_BITS bits: go to PARITY if PARITY != 0, else STOP.
- PARITY:
  - Compare the voted bit against the XOR of the payload (inverted for odd).
  - Latch the mismatch, then -> STOP.
- STOP:
  - Vote each stop bit at count 9; any 0 sets frame_err.
  - With STOP_BITS=2 the second bit is checked likewise.
  - After the last stop bit is voted (count 9, not 15, to allow early resync), the next cycle:
    - rx_data <= shift register;
    - frame_err and parity_err update;
    - rx_done = 1 for exactly one cycle;
    - FSM -> IDLE.
- Output holding: rx_data, frame_err and parity_err hold until the next rx_done.
- Framing-error recovery: if the line is still low in IDLE after a frame error, no new start is taken until a 1->0 edge is seen.
- Latency: rx_done asserts about (1 + DATA_BITS + P + STOP_BITS - 0.5) bit times plus 3 clk after the start falling edge (P = 1 if parity enabled, else 0).
- Reset mid-frame: frame is abandoned, no rx_done, outputs return to 0.
- Glitch shorter than 8 samples inside the start bit is rejected by the false-start check.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- When defined:
  - Adds output port break_det (1 bit, reset 0).
  - A frame with all data bits 0, parity bit 0 (if enabled) and a low stop bit raises break_det in the rx_done cycle; frame_err is also 1.
  - FSM enters BREAK and stays until the line has been high for 16 consecutive samples, then returns to IDLE.
  - break_det is held high until the BREAK exit.
- When undefined:
  - No port, no BREAK state.
  - A break frame is reported only as frame_err with rx_data=0.

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE/ODD/EVEN constants;
  - the state encoding (IDLE, START, DATA, PARITY, STOP, BREAK);
  - OVERSAMPLE=16;
  - a function computing DIV from CLK_FREQ and BAUD.
- Sub-module uart_baud_gen (parameter DIV; inputs clk, rst_n, clr; output tick). It is reused later by the matching parametrised transmitter.

Test Plan:
- Use defaults, clk 20 ns, DIV=27 (432 clk per bit).
- Drive 8N1 0x55 -> one rx_done pulse; rx_data=0x55; frame_err=0; parity_err=0; busy low afterwards.
- PARITY=2, DATA_BITS=7, send 0x3A with parity bit 0 (correct even) -> parity_err=0. Resend with parity bit 1 -> parity_err=1, rx_data=0x3A.
- Stop bit driven low for 0x0F -> rx_done with frame_err=1; next frame 0xA5 is received cleanly after line high.
- 100 ns low glitch on idle line -> no rx_done, busy returns low within 10 bit-sample ticks.
- STOP_BITS=2, second stop bit low, byte 0xC3 -> frame_err=1. Separately, assert rst_n low mid-DATA -> outputs 0, no rx_done, next 0x81 received correctly.
- With UART_RX_BREAK_DET_EN: hold rx low for 12 bit times -> break_det=1 and frame_err=1 with rx_done, rx_data=0x00. break_det clears 16 samples after the line returns high.
